// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and types for the register file
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: operand-store port bundle (one write, two registered reads)
interface register_file_if;
  import regfile_pkg::*;
  logic EN;
  logic WR;
  logic RD;
  word_t Ip1;
  addr_t sel_i1;
  addr_t sel_o1;
  addr_t sel_o2;
  word_t Op1;
  word_t Op2;
  modport master (output EN, WR, RD, Ip1, sel_i1, sel_o1, sel_o2, input Op1, Op2);
  modport slave (input EN, WR, RD, Ip1, sel_i1, sel_o1, sel_o2, output Op1, Op2);
endinterface

// File: rtl/register_file.sv
// register_file: 16x32 register file, one write port, two registered read ports
module register_file
  import regfile_pkg::*;
(
  input logic clk,
  input logic rst,
  register_file_if.slave bus
);
  word_t r_mem [DEPTH];
  word_t r_op1;
  word_t r_op2;
  logic w_wr;
  logic w_rd;
  assign w_wr = bus.EN & bus.WR;
  assign w_rd = bus.EN & bus.RD;
  // reads sample r_mem before this edge's write lands, giving read-before-write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
    end else begin
      if (w_wr) r_mem[bus.sel_i1] <= bus.Ip1;
      if (w_rd) begin
        r_op1 <= r_mem[bus.sel_o1];
        r_op2 <= r_mem[bus.sel_o2];
      end
    end
  end
  assign bus.Op1 = r_op1;
  assign bus.Op2 = r_op2;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plus random stimulus checked against an array model
module tb_register_file;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  word_t model [DEPTH];
  word_t exp1 = '0;
  word_t exp2 = '0;
  register_file_if bus ();
  register_file dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic wr, input logic rd,
                     input word_t d, input addr_t wa, input addr_t a1, input addr_t a2);
    word_t old [DEPTH];
    rst = r; bus.EN = en; bus.WR = wr; bus.RD = rd;
    bus.Ip1 = d; bus.sel_i1 = wa; bus.sel_o1 = a1; bus.sel_o2 = a2;
    @(posedge clk);
    old = model;
    if (r) begin
      foreach (model[i]) model[i] = '0;
      exp1 = '0;
      exp2 = '0;
    end else if (en) begin
      if (rd) begin
        exp1 = old[a1];
        exp2 = old[a2];
      end
      if (wr) model[wa] = d;
    end
    #1;
    check("op1", bus.Op1, exp1);
    check("op2", bus.Op2, exp2);
  endtask

  initial begin
    bus.EN = 0; bus.WR = 0; bus.RD = 0; bus.Ip1 = '0;
    bus.sel_i1 = '0; bus.sel_o1 = '0; bus.sel_o2 = '0;
    foreach (model[i]) model[i] = '0;
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 1'($urandom), 1'($urandom), $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
    check("reset_op1", bus.Op1, 32'h0);
    for (int i = 0; i < DEPTH; i += 2) cyc(0, 1, 0, 1, '0, '0, addr_t'(i), addr_t'(i + 1));
    cyc(0, 1, 1, 0, 32'hABCD_EFAB, 4'd0, 4'd0, 4'd0);
    cyc(0, 1, 1, 0, 32'h0123_4567, 4'd1, 4'd0, 4'd0);
    cyc(0, 1, 0, 1, '0, 4'd0, 4'd0, 4'd1);
    check("basic_op1", bus.Op1, 32'hABCD_EFAB);
    check("basic_op2", bus.Op2, 32'h0123_4567);
    cyc(0, 0, 1, 0, 32'hDEAD_BEEF, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0, 1, '0, 4'd0, 4'd7, 4'd8);
    check("en_hold_op1", bus.Op1, 32'hABCD_EFAB);
    cyc(0, 1, 0, 1, '0, 4'd0, 4'd0, 4'd0);
    check("en_gate_wr", bus.Op2, 32'hABCD_EFAB);
    cyc(0, 1, 1, 0, 32'h7777_0000, 4'd3, 4'd1, 4'd3);
    check("rd_hold_op1", bus.Op1, 32'hABCD_EFAB);
    cyc(0, 1, 1, 1, 32'h5555_AAAA, 4'd5, 4'd5, 4'd5);
    check("rbw_old", bus.Op1, 32'h0);
    cyc(0, 1, 0, 1, '0, 4'd0, 4'd5, 4'd3);
    check("rbw_new", bus.Op1, 32'h5555_AAAA);
    check("rd_hold_wr", bus.Op2, 32'h7777_0000);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, 0, 32'h1111_1111 * i, addr_t'(i), '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 1, '0, '0, addr_t'(i), addr_t'(15 - i));
      check("sweep_op1", bus.Op1, 32'h1111_1111 * i);
      check("sweep_op2", bus.Op2, 32'h1111_1111 * (15 - i));
      if (i == 7) begin
        cyc(1, 1, 1, 1, 32'hFFFF_FFFF, 4'd2, 4'd3, 4'd4);
        check("mid_rst_op1", bus.Op1, 32'h0);
        check("mid_rst_op2", bus.Op2, 32'h0);
        break;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 1, '0, '0, addr_t'(i), addr_t'(15 - i));
      check("post_rst", bus.Op1 | bus.Op2, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
